// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the ALU sequencing controller and the front panel, the functional
// units and the display driver. The controller uses the master side.
interface alu_seq_ctrl_if;
    logic        start;
    logic [2:0]  portA;
    logic [2:0]  portB;
    logic [1:0]  opcode;
    logic [3:0]  sal_sh_l;
    logic [3:0]  sal_sh_r;
    logic [5:0]  sal_isZero;
    logic [3:0]  sal_div;
    logic        div_done;
    logic [2:0]  op_a;
    logic [2:0]  op_b;
    logic [3:0]  init;
    logic [15:0] int_bcd;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, portA, portB, opcode,
        input  sal_sh_l, sal_sh_r, sal_isZero, sal_div, div_done,
        output op_a, op_b, init, int_bcd, busy, done, err
    );

    modport slave (
        output start, portA, portB, opcode,
        output sal_sh_l, sal_sh_r, sal_isZero, sal_div, div_done,
        input  op_a, op_b, init, int_bcd, busy, done, err
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the 3-bit ALU: latches a request, pulses one functional unit,
// waits for its result and packs it into the 16-bit display word with status flags.
module alu_seq_ctrl #(
    parameter int COMB_LAT = 1,
    parameter int TIMEOUT  = 31
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.master bus
);
    localparam int MAX_WAIT = (COMB_LAT > TIMEOUT) ? COMB_LAT : TIMEOUT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(COMB_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]      ERR_WORD = {4'h3, 12'hFFF};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t           state_reg;
    logic             start_q_reg;
    logic             armed_reg;
    logic [1:0]       op_q_reg;
    logic [2:0]       op_a_reg;
    logic [2:0]       op_b_reg;
    logic [3:0]       init_reg;
    logic [15:0]      int_bcd_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic        accept;
    logic        div_by_zero;
    logic [3:0]  req_sel;
    logic [15:0] result_word;

    // armed_reg blocks a start level that was already high when reset released
    assign accept      = bus.start && !start_q_reg && armed_reg;
    assign div_by_zero = (bus.opcode == 2'b11) && (bus.portB == 3'b000);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req_sel
            assign req_sel[gi] = (bus.opcode == 2'(gi));
        end
    endgenerate

    always_comb begin
        result_word = 16'h0000;
        case (op_q_reg)
            2'b00:   result_word = {4'h0, 8'h00, bus.sal_sh_l};
            2'b01:   result_word = {4'h1, 8'h00, bus.sal_sh_r};
            2'b10:   result_word = {4'h2, 6'h00, bus.sal_isZero};
            default: result_word = {4'h3, 8'h00, bus.sal_div};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            start_q_reg <= 1'b0;
            armed_reg   <= 1'b0;
            op_q_reg    <= 2'b00;
            op_a_reg    <= 3'b000;
            op_b_reg    <= 3'b000;
            init_reg    <= 4'b0000;
            int_bcd_reg <= 16'h0000;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            start_q_reg <= bus.start;
            if (!bus.start) begin
                armed_reg <= 1'b1;
            end
            init_reg <= 4'b0000;
            done_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_a_reg <= bus.portA;
                        op_b_reg <= bus.portB;
                        op_q_reg <= bus.opcode;
                        err_reg  <= 1'b0;
                        if (div_by_zero) begin
                            int_bcd_reg <= ERR_WORD;
                            err_reg     <= 1'b1;
                            done_reg    <= 1'b1;
                        end else begin
                            init_reg  <= req_sel;
                            busy_reg  <= 1'b1;
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (op_q_reg != 2'b11) begin
                        if (cnt_reg == LAT_LAST) begin
                            int_bcd_reg <= result_word;
                            done_reg    <= 1'b1;
                            busy_reg    <= 1'b0;
                            state_reg   <= S_IDLE;
                        end
                    end else if (bus.div_done) begin
                        int_bcd_reg <= result_word;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= S_IDLE;
                    end else if (cnt_reg == TO_LAST) begin
                        int_bcd_reg <= ERR_WORD;
                        err_reg     <= 1'b1;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= S_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_a    = op_a_reg;
    assign bus.op_b    = op_b_reg;
    assign bus.init    = init_reg;
    assign bus.int_bcd = int_bcd_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
endmodule
